nibble_serial_add_ctrl: RTL and testbench

Sequencer that performs a WIDTH-bit addition by time-multiplexing one 4-bit carry-lookahead adder slice over WIDTH/4 clock cycles, least-significant nibble first.
- Carry is held in a register between slices.
- Operands arrive on a valid/ready input handshake; the result leaves on a valid/ready output handshake.
- Lets wide adds reuse the team's existing 4-bit CLA datapath instead of instantiating a wide adder.

---
 rtl/nibble_serial_add_ctrl_if.sv | 35 +++
 rtl/nibble_serial_add_ctrl.sv | 120 ++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_add_ctrl_if.sv
// Handshake bundle for the nibble-serial adder.
// Optional sub port exists only when ADD_SUB_EN is defined.
interface nibble_serial_add_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef ADD_SUB_EN
  logic             sub;
`endif

  modport master (
`ifdef ADD_SUB_EN
    output sub,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
`ifdef ADD_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add over WIDTH/4 cycles through one 4-bit CLA slice.
// Define ADD_SUB_EN to add the sub port (a-b via ~b and carry 1).
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  nibble_serial_add_ctrl_if.slave bus
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_q;
  logic             cy, cout_q, ov_q;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic [3:0]       g, p;
  logic [4:0]       c;
  logic [4:0]       s;

`ifdef ADD_SUB_EN
  assign b_in = bus.sub ? ~bus.b : bus.b;
  assign c_in = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_in = bus.b;
  assign c_in = bus.cin;
`endif

  // 4-bit carry-lookahead slice on the low nibble of the shift regs
  always_comb begin
    g    = a_sh[3:0] & b_sh[3:0];
    p    = a_sh[3:0] ^ b_sh[3:0];
    c[0] = cy;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s    = {c[4], p ^ c[3:0]};
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.in_valid)   state_nx = RUN;
      RUN:  if (cnt == LAST)    state_nx = DONE;
      DONE: if (bus.out_ready)  state_nx = IDLE;
      default:                  state_nx = IDLE;
    endcase
  end

  // operand capture, per-nibble sum build, carry and result flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      cy     <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh  <= bus.a;
            b_sh  <= b_in;
            cy    <= c_in;
            cnt   <= '0;
            sum_q <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NIB; i++) begin
            if (cnt == CW'(i)) sum_q[4*i +: 4] <= s[3:0];
          end
          cy   <= s[4];
          a_sh <= a_sh >> 4;
          b_sh <= b_sh >> 4;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            cout_q <= s[4];
            ov_q   <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) ov_q <= 1'b0;
        end
        default: ov_q <= 1'b0;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = ov_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl (WIDTH 16 and 4).
// Build with ADD_SUB_EN defined to exercise subtraction too.
module tb_nibble_serial_add_ctrl;

  localparam int NIB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nibble_serial_add_ctrl_if #(.WIDTH(16)) ifc ();
  nibble_serial_add_ctrl_if #(.WIDTH(4))  ifc4 ();

  nibble_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc4.slave)
  );

  typedef struct {
    logic [15:0] s;
    logic        c;
    longint      acc;
  } exp_t;

  exp_t   q[$];
  int     n_chk = 0;
  int     n_fail = 0;
  longint cyc = 0;
  int     ready_mode = 1;
  logic   rnd_rdy = 1'b0;
  logic   prev_ov = 1'b0;

  always @(posedge clk) cyc++;
  always @(posedge clk) rnd_rdy <= 1'($urandom_range(0, 1));

  assign ifc.out_ready = (ready_mode == 2) ? rnd_rdy : ready_mode[0];
  assign ifc4.out_ready = 1'b1;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // monitor: latency on rising out_valid, data on each handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (ifc.out_valid && !prev_ov) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out_valid sum=%0h", ifc.sum);
        end else begin
          check("latency", 32'(cyc - q[0].acc), NIB);
        end
      end
      if (ifc.out_valid && ifc.out_ready && q.size() != 0) begin
        check("sum", {16'h0, ifc.sum}, {16'h0, q[0].s});
        check("cout", {31'h0, ifc.cout}, {31'h0, q[0].c});
        void'(q.pop_front());
      end
      prev_ov = ifc.out_valid;
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic ci, input logic sb);
    exp_t        e;
    int          w;
    logic [16:0] r;
    ifc.a  = a;
    ifc.b  = b;
    ifc.cin = ci;
`ifdef ADD_SUB_EN
    ifc.sub = sb;
`endif
    ifc.in_valid = 1'b1;
    w = 0;
    while (1) begin
      @(negedge clk);
      if (ifc.in_ready && rst_n) break;
      w++;
      if (w > 100) break;
    end
    if (w > 100) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout got=busy exp=accept");
      ifc.in_valid = 1'b0;
      return;
    end
    if (sb) r = {1'b0, a} + {1'b0, ~b} + 17'd1;
    else    r = {1'b0, a} + {1'b0, b} + {16'h0, ci};
    e.s   = r[15:0];
    e.c   = r[16];
    e.acc = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 300) begin
      @(posedge clk);
      w++;
    end
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout got=%0d exp=0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          w;
    logic [15:0] ra, rb;
    logic        rc, rs;
    logic [4:0]  r4;

    ifc.in_valid  = 1'b0;
    ifc.a         = '0;
    ifc.b         = '0;
    ifc.cin       = 1'b0;
    ifc4.in_valid = 1'b0;
    ifc4.a        = '0;
    ifc4.b        = '0;
    ifc4.cin      = 1'b0;
`ifdef ADD_SUB_EN
    ifc.sub  = 1'b0;
    ifc4.sub = 1'b0;
`endif

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'h0, ifc.in_ready}, 1);
    check("rst_out_valid", {31'h0, ifc.out_valid}, 0);
    check("rst_busy", {31'h0, ifc.busy}, 0);
    check("rst_sum", {16'h0, ifc.sum}, 0);
    check("rst_cout", {31'h0, ifc.cout}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic adds and full carry chains
    send(16'h1234, 16'h4321, 1'b0, 1'b0);
    check("busy_after_accept", {31'h0, ifc.busy}, 1);
    check("in_ready_after_accept", {31'h0, ifc.in_ready}, 0);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    drain();

    // backpressure with a pending operand set
    ready_mode = 0;
    send(16'h00F0, 16'h0010, 1'b0, 1'b0);
    fork
      send(16'h1111, 16'h2222, 1'b1, 1'b0);
      begin
        w = 0;
        while (1) begin
          @(negedge clk);
          if (ifc.out_valid || w > 50) break;
          w++;
        end
        check("bp_seen_valid", {31'h0, ifc.out_valid}, 1);
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          check("bp_sum_hold", {16'h0, ifc.sum}, 32'h0100);
          check("bp_out_valid", {31'h0, ifc.out_valid}, 1);
          check("bp_in_ready", {31'h0, ifc.in_ready}, 0);
        end
        @(posedge clk);
        #1 ready_mode = 1;
      end
    join
    drain();

    // asynchronous reset in the second RUN cycle
    send(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'h0, ifc.out_valid}, 0);
    check("mid_rst_sum", {16'h0, ifc.sum}, 0);
    check("mid_rst_cout", {31'h0, ifc.cout}, 0);
    check("mid_rst_busy", {31'h0, ifc.busy}, 0);
    check("mid_rst_in_ready", {31'h0, ifc.in_ready}, 1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(16'h0001, 16'h0001, 1'b0, 1'b0);
    drain();

`ifdef ADD_SUB_EN
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    send(16'h0007, 16'h0005, 1'b1, 1'b1);
    send(16'h1234, 16'h4321, 1'b0, 1'b0);
    drain();
`endif

    // randomized traffic with random backpressure
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
`ifdef ADD_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      send(ra, rb, rc, rs);
    end
    ready_mode = 1;
    drain();

    // WIDTH=4 instance: single RUN cycle
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        ifc4.a = 4'h9; ifc4.b = 4'h8; ifc4.cin = 1'b1;
      end else begin
        ifc4.a   = 4'($urandom);
        ifc4.b   = 4'($urandom);
        ifc4.cin = 1'($urandom_range(0, 1));
      end
      r4 = {1'b0, ifc4.a} + {1'b0, ifc4.b} + {4'h0, ifc4.cin};
      ifc4.in_valid = 1'b1;
      @(negedge clk);
      check("w4_in_ready", {31'h0, ifc4.in_ready}, 1);
      @(posedge clk);
      #1 ifc4.in_valid = 1'b0;
      @(negedge clk);
      check("w4_not_yet", {31'h0, ifc4.out_valid}, 0);
      @(negedge clk);
      check("w4_valid", {31'h0, ifc4.out_valid}, 1);
      check("w4_sum", {28'h0, ifc4.sum}, {28'h0, r4[3:0]});
      check("w4_cout", {31'h0, ifc4.cout}, {31'h0, r4[4]});
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
